// File: rtl/nmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nmp_pkg
// Description : Shared types and constants for the near-memory processor
//               command sequencer: command and state encodings, default
//               memory width, AXI-lite register offsets, status bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package nmp_pkg;

    localparam int MEM_BITS_DEF = 12;
    localparam int DATA_W_DEF   = 32;

    // Command codes as written by software into op_reg.
    typedef enum logic [1:0] {
        OP_WAIT  = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_ADD   = 2'd3
    } op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_ISS = 3'd1,
        S_RD_CAP = 3'd2,
        S_WR_ISS = 3'd3,
        S_ADD_A  = 3'd4,
        S_ADD_B  = 3'd5,
        S_ADD_W  = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    // AXI-lite register bank byte offsets.
    localparam logic [7:0] c_REG_OP         = 8'h00;
    localparam logic [7:0] c_REG_ADDR       = 8'h04;
    localparam logic [7:0] c_REG_STATUS     = 8'h08;
    localparam logic [7:0] c_REG_DATA_READ  = 8'h0C;
    localparam logic [7:0] c_REG_DATA_WRITE = 8'h10;
    localparam logic [7:0] c_REG_VECA       = 8'h14;
    localparam logic [7:0] c_REG_VECB       = 8'h18;
    localparam logic [7:0] c_REG_VECR       = 8'h1C;
    localparam logic [7:0] c_REG_LEN        = 8'h20;

    // status_reg bit positions.
    localparam int c_STAT_DONE_BIT = 0;
    localparam int c_STAT_BUSY_BIT = 1;

endpackage : nmp_pkg
`default_nettype wire

// File: rtl/nmp_vec_agu.sv
`default_nettype none
// ============================================================================
// Module      : nmp_vec_agu
// Description : Vector address generator. Holds the element index, forms
//               the three element addresses (base + idx, wrapping modulo
//               memory depth) and flags the last element of the vector.
// Ports       : clk, rst_n (async active-low)
//               clr      - restart index at 0
//               inc      - advance index by one element
//               veca/vecb/vecr - latched base addresses
//               len      - latched vector length (MEM_BITS+1 bits)
//               addr_a/addr_b/addr_r - element addresses for current idx
//               last     - current element is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module nmp_vec_agu
    import nmp_pkg::*;
#(
    parameter int MEM_BITS = MEM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                inc,
    input  logic [MEM_BITS-1:0] veca,
    input  logic [MEM_BITS-1:0] vecb,
    input  logic [MEM_BITS-1:0] vecr,
    input  logic [MEM_BITS:0]   len,
    output logic [MEM_BITS-1:0] addr_a,
    output logic [MEM_BITS-1:0] addr_b,
    output logic [MEM_BITS-1:0] addr_r,
    output logic                last
);

    // One bit wider than the address so lengths up to 2*depth-1 count out.
    logic [MEM_BITS:0] r_idx;
    logic [MEM_BITS:0] w_idx_inc;

    assign w_idx_inc = r_idx + {{MEM_BITS{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (inc) begin
            r_idx <= w_idx_inc;
        end
    end

    // Dropping the index MSB makes the sum wrap modulo the memory depth.
    assign addr_a = veca + r_idx[MEM_BITS-1:0];
    assign addr_b = vecb + r_idx[MEM_BITS-1:0];
    assign addr_r = vecr + r_idx[MEM_BITS-1:0];
    assign last   = (w_idx_inc == len);

endmodule : nmp_vec_agu
`default_nettype wire

// File: rtl/nmp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nmp_seq_ctrl
// Description : Near-memory processor command sequencer. Executes READ,
//               WRITE and vector ADD (R[i] = A[i] + B[i]) against a
//               single-port BRAM with one-cycle read latency, and holds
//               done until software returns op to WAIT.
// Ports       : ACLK, ARESETn (async active-low)
//               op_i, addr_i, wdata_i, veca_i, vecb_i, vecr_i, len_i
//                        - register bank inputs, sampled on the start cycle
//               done_o, busy_o, rdata_o - status / data_read outputs
//               mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_rdata_i
//                        - BRAM port
//               cyc_cnt_o - busy-cycle counter (only with NMP_CYCLE_CNT_EN)
// Options     : `define NMP_CYCLE_CNT_EN adds the saturating cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module nmp_seq_ctrl
    import nmp_pkg::*;
#(
    parameter int MEM_BITS = MEM_BITS_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [1:0]          op_i,
    input  logic [31:0]         addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [31:0]         veca_i,
    input  logic [31:0]         vecb_i,
    input  logic [31:0]         vecr_i,
    input  logic [31:0]         len_i,
`ifdef NMP_CYCLE_CNT_EN
    output logic [31:0]         cyc_cnt_o,
`endif
    output logic                done_o,
    output logic                busy_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [MEM_BITS-1:0] mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    state_e              r_state;
    state_e              w_state_nxt;
    op_e                 w_op;
    logic                w_start;

    logic [MEM_BITS-1:0] r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MEM_BITS-1:0] r_veca;
    logic [MEM_BITS-1:0] r_vecb;
    logic [MEM_BITS-1:0] r_vecr;
    logic [MEM_BITS:0]   r_len;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_rdata;

    logic [MEM_BITS-1:0] w_addr_a;
    logic [MEM_BITS-1:0] w_addr_b;
    logic [MEM_BITS-1:0] w_addr_r;
    logic                w_last;

    // Register bits above the memory range carry no meaning here.
    logic w_unused;
    assign w_unused = ^{addr_i[31:MEM_BITS], veca_i[31:MEM_BITS],
                        vecb_i[31:MEM_BITS], vecr_i[31:MEM_BITS],
                        len_i[31:MEM_BITS+1]};

    assign w_op    = op_e'(op_i);
    assign w_start = (r_state == S_IDLE) && (w_op != OP_WAIT);

    // ------------------------------------------------------------------
    // State register and operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_veca  <= '0;
            r_vecb  <= '0;
            r_vecr  <= '0;
            r_len   <= '0;
            r_opa   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_addr  <= addr_i[MEM_BITS-1:0];
                r_wdata <= wdata_i;
                r_veca  <= veca_i[MEM_BITS-1:0];
                r_vecb  <= vecb_i[MEM_BITS-1:0];
                r_vecr  <= vecr_i[MEM_BITS-1:0];
                r_len   <= len_i[MEM_BITS:0];
            end
            // A read issued in ADD_A returns during ADD_B.
            if (r_state == S_ADD_B) begin
                r_opa <= mem_rdata_i;
            end
            if (r_state == S_RD_CAP) begin
                r_rdata <= mem_rdata_i;
            end
        end
    end

    nmp_vec_agu #(
        .MEM_BITS (MEM_BITS)
    ) u_agu (
        .clk    (ACLK),
        .rst_n  (ARESETn),
        .clr    (w_start),
        .inc    (r_state == S_ADD_W),
        .veca   (r_veca),
        .vecb   (r_vecb),
        .vecr   (r_vecr),
        .len    (r_len),
        .addr_a (w_addr_a),
        .addr_b (w_addr_b),
        .addr_r (w_addr_r),
        .last   (w_last)
    );

    // ------------------------------------------------------------------
    // Next state and BRAM port
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (r_state)
            S_IDLE: begin
                case (w_op)
                    OP_READ:  w_state_nxt = S_RD_ISS;
                    OP_WRITE: w_state_nxt = S_WR_ISS;
                    // Length is taken straight from the input on the start
                    // cycle because the latched copy is not loaded yet.
                    OP_ADD:   w_state_nxt = (len_i[MEM_BITS:0] == '0) ? S_DONE : S_ADD_A;
                    default:  w_state_nxt = S_IDLE;
                endcase
            end
            S_RD_ISS: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = r_addr;
                w_state_nxt = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_state_nxt = S_DONE;
            end
            S_WR_ISS: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
                w_state_nxt = S_DONE;
            end
            S_ADD_A: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = w_addr_a;
                w_state_nxt = S_ADD_B;
            end
            S_ADD_B: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = w_addr_b;
                w_state_nxt = S_ADD_W;
            end
            S_ADD_W: begin
                // B arrives this cycle; sum wraps at DATA_W bits.
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = w_addr_r;
                mem_wdata_o = r_opa + mem_rdata_i;
                w_state_nxt = w_last ? S_DONE : S_ADD_A;
            end
            S_DONE: begin
                // Any non-WAIT op, even a different one, keeps us here.
                if (w_op == OP_WAIT) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign done_o  = (r_state == S_DONE);
    assign busy_o  = (r_state != S_IDLE) && (r_state != S_DONE);
    assign rdata_o = r_rdata;

`ifdef NMP_CYCLE_CNT_EN
    logic [31:0] r_cyc_cnt;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_cyc_cnt <= '0;
        end else if (w_start) begin
            r_cyc_cnt <= '0;
        end else if (busy_o && (r_cyc_cnt != '1)) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign cyc_cnt_o = r_cyc_cnt;
`endif

endmodule : nmp_seq_ctrl
`default_nettype wire

// File: tb/tb_nmp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmp_seq_ctrl
// Description : Self-checking bench for nmp_seq_ctrl. A behavioural BRAM
//               serves the DUT; a reference memory is updated with
//               whole-operation semantics (READ/WRITE/element-wise ADD) and
//               compared against the BRAM, read data, latency and access
//               counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmp_seq_ctrl;

    localparam int MB    = 12;
    localparam int DEPTH = 4096;

    logic        tb_ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [1:0]  op_i    = 2'd0;
    logic [31:0] addr_i  = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] veca_i  = '0;
    logic [31:0] vecb_i  = '0;
    logic [31:0] vecr_i  = '0;
    logic [31:0] len_i   = '0;
    logic        done_o;
    logic        busy_o;
    logic [31:0] rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
`ifdef NMP_CYCLE_CNT_EN
    logic [31:0] cyc_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int we_bad = 0;

    logic [31:0] bram    [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    always #5 tb_ACLK = ~tb_ACLK;

    nmp_seq_ctrl dut (
        .ACLK        (tb_ACLK),
        .ARESETn     (ARESETn),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .veca_i      (veca_i),
        .vecb_i      (vecb_i),
        .vecr_i      (vecr_i),
        .len_i       (len_i),
`ifdef NMP_CYCLE_CNT_EN
        .cyc_cnt_o   (cyc_cnt_o),
`endif
        .done_o      (done_o),
        .busy_o      (busy_o),
        .rdata_o     (rdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    // Read-first single-port BRAM, one-cycle read latency.
    always @(posedge tb_ACLK) begin
        if (mem_en_o) begin
            if (mem_we_o) bram[mem_addr_o] <= mem_wdata_o;
            mem_rdata_i <= bram[mem_addr_o];
        end
    end

    always @(negedge tb_ACLK) begin
        if (mem_we_o === 1'b1 && mem_en_o !== 1'b1) we_bad++;
    end

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics of one ADD command, element by element.
    task automatic ref_add(input int unsigned va, vb, vr, n);
        for (int i = 0; i < int'(n); i++) begin
            ref_mem[(vr + i) % DEPTH] = ref_mem[(va + i) % DEPTH] + ref_mem[(vb + i) % DEPTH];
        end
    endtask

    // Issue one command, follow it to done, check it, optionally release.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, d, va, vb, vr, ln,
                          input bit release_done);
        int unsigned n, bc, ec, exp_n, l, budget, bad_addr;
        logic [31:0] rd_before;
        logic        f_we;
        logic [11:0] f_addr;
        logic [31:0] f_wdata;
        logic [11:0] wq[$];
        bit          seen;
        l         = ln & 32'h1FFF;
        rd_before = rdata_o;
        exp_n     = (op == 2'd1) ? 3 : (op == 2'd2) ? 2 : ((l == 0) ? 1 : 3 * l + 1);
        budget    = 3 * l + 10;
        addr_i = a; wdata_i = d; veca_i = va; vecb_i = vb; vecr_i = vr; len_i = ln;
        op_i   = op;
        n = 0; bc = 0; ec = 0; seen = 0;
        f_we = 0; f_addr = '0; f_wdata = '0;
        while (n < budget) begin
            tick();
            n++;
            if (done_o === 1'b1) break;
            if (busy_o) bc++;
            if (mem_en_o) begin
                ec++;
                if (!seen) begin
                    seen = 1; f_we = mem_we_o; f_addr = mem_addr_o; f_wdata = mem_wdata_o;
                end
                if (mem_we_o) wq.push_back(mem_addr_o);
            end
            // Operands must already be latched; disturb the inputs.
            addr_i = $urandom; wdata_i = $urandom; veca_i = $urandom;
            vecb_i = $urandom; vecr_i = $urandom; len_i = $urandom;
        end
        chk({tag, " latency"}, 64'(n), 64'(exp_n));
        chk({tag, " busy_cycles"}, 64'(bc), 64'((op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 3 * l));
        chk({tag, " en_cycles"}, 64'(ec), 64'((op == 2'd3) ? 3 * l : 1));
`ifdef NMP_CYCLE_CNT_EN
        chk({tag, " cyc_cnt"}, 64'(cyc_cnt_o), 64'((op == 2'd1) ? 2 : (op == 2'd2) ? 1 : 3 * l));
`endif
        case (op)
            2'd1: begin
                chk({tag, " rd_access"}, {51'd0, f_we, f_addr}, {51'd0, 1'b0, a[11:0]});
                chk({tag, " rdata"}, 64'(rdata_o), 64'(ref_mem[a % DEPTH]));
            end
            2'd2: begin
                chk({tag, " wr_access"}, {19'd0, f_we, f_addr, f_wdata}, {19'd0, 1'b1, a[11:0], d});
                ref_mem[a % DEPTH] = d;
                chk({tag, " rdata_kept"}, 64'(rdata_o), 64'(rd_before));
            end
            default: begin
                ref_add(va, vb, vr, l);
                bad_addr = 0;
                for (int i = 0; i < wq.size(); i++)
                    if (wq[i] != 12'((vr + i) % DEPTH)) bad_addr++;
                chk({tag, " wr_addr_seq"}, {32'(wq.size()), 32'(bad_addr)}, {32'(l), 32'd0});
            end
        endcase
        if (release_done) begin
            op_i = 2'd0;
            tick();
            chk({tag, " done_clear"}, {62'd0, done_o, busy_o}, 64'd0);
        end
    endtask

    initial begin
        int unsigned memdiff, hold_en, hold_busy, hold_done;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = $urandom;
            ref_mem[i] = bram[i];
        end

        // ---- reset state ----
        repeat (3) tick();
        chk("reset outputs", {59'd0, done_o, busy_o, mem_en_o, mem_we_o, 1'b0}, 64'd0);
        chk("reset addr_wdata", {20'd0, mem_addr_o, mem_wdata_o}, 64'd0);
        chk("reset rdata", 64'(rdata_o), 64'd0);
        ARESETn = 1'b1;
        tick();
        chk("idle after reset", {62'd0, done_o, busy_o}, 64'd0);

        // ---- basic write / add / read ----
        run_op("wr2",  2'd2, 32'd2, 32'd16, 0, 0, 0, 0, 1);
        run_op("wr4",  2'd2, 32'd4, 32'd32, 0, 0, 0, 0, 1);
        run_op("add1", 2'd3, 0, 0, 32'd2, 32'd4, 32'd8, 32'd1, 1);
        run_op("rd8",  2'd1, 32'd8, 0, 0, 0, 0, 0, 1);
        chk("rd8 sum", 64'(rdata_o), 64'd48);

        // ---- zero length ----
        run_op("add0", 2'd3, 0, 0, 32'd10, 32'd20, 32'd30, 32'h0000_6000, 1);

        // ---- wrap-around add with carry drop ----
        bram[4094] = 32'hFFFF_FFFF; ref_mem[4094] = 32'hFFFF_FFFF;
        bram[100]  = 32'd2;         ref_mem[100]  = 32'd2;
        run_op("addwrap", 2'd3, 0, 0, 32'd4094, 32'd100, 32'd4095, 32'd3, 1);
        chk("addwrap carry", 64'(bram[4095]), 64'd1);

        // ---- done holds across a different non-WAIT op ----
        run_op("rdhold", 2'd1, 32'd4095, 0, 0, 0, 0, 0, 0);
        hold_en = 0; hold_busy = 0; hold_done = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_en_o) hold_en++;
            if (busy_o) hold_busy++;
            if (done_o) hold_done++;
        end
        op_i = 2'd2; addr_i = 32'd5; wdata_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_en_o) hold_en++;
            if (busy_o) hold_busy++;
            if (done_o) hold_done++;
        end
        chk("hold no_access", {32'(hold_en), 32'(hold_busy)}, 64'd0);
        chk("hold done", 64'(hold_done), 64'd7);
        op_i = 2'd0;
        tick();
        chk("hold release", {63'd0, done_o}, 64'd0);

        // ---- reset in the middle of a long add ----
        veca_i = 32'd1000; vecb_i = 32'd1200; vecr_i = 32'd1400; len_i = 32'd100;
        op_i = 2'd3;
        repeat (40) tick();
        ARESETn = 1'b0;
        #1;
        chk("midreset outputs", {59'd0, done_o, busy_o, mem_en_o, mem_we_o, 1'b0}, 64'd0);
        chk("midreset addr_rdata", {20'd0, mem_addr_o, rdata_o}, 64'd0);
        // Three cycles per element: 13 elements committed by this point.
        ref_add(1000, 1200, 1400, 13);
        op_i = 2'd0;
        tick();
        ARESETn = 1'b1;
        tick();
        run_op("add_after_reset", 2'd3, 0, 0, 32'd1000, 32'd1200, 32'd1400, 32'd5, 1);

        // ---- randomized command mix ----
        for (int k = 0; k < 30; k++) begin
            logic [1:0]  rop;
            logic [31:0] rl;
            rop = 2'($urandom_range(1, 3));
            rl  = ($urandom & 32'hFFFF_E000) | 32'($urandom_range(0, 6));
            run_op($sformatf("rand%0d", k), rop, $urandom, $urandom,
                   $urandom, $urandom, $urandom, rl, 1);
        end

        // ---- final memory image ----
        tick();
        memdiff = 0;
        for (int i = 0; i < DEPTH; i++)
            if (bram[i] !== ref_mem[i]) memdiff++;
        chk("memory image", 64'(memdiff), 64'd0);
        chk("we_without_en", 64'(we_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_nmp_seq_ctrl
`default_nettype wire
